// File: rtl/mpsoc_uart_bus_bridge_pkg.sv
// Shared types and constants for the UART-to-peripheral-bus bridge.
package mpsoc_uart_bus_bridge_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ALO,
        S_GET_DLO,
        S_GET_DHI,
        S_BUS,
        S_SEND_B0,
        S_SEND_B1
    } state_t;

    localparam int         CMD_WR_BIT = 7;
    localparam logic [7:0] ACK_BYTE   = 8'hA5;
    localparam int         ADDR_HI_W  = 6;
endpackage

// File: rtl/mpsoc_uart_bus_bridge_tx.sv
// 8N1 serializer; a load in the last stop-bit cycle chains frames without a gap.
module mpsoc_uart_bus_bridge_tx #(
    parameter int BAUD_DIV = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic [7:0] i_byte,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_txd
);
    localparam int CW = $clog2(BAUD_DIV);

    logic [CW-1:0] r_cnt;
    logic [3:0]    r_bit;
    logic [8:0]    r_sh;
    logic          r_busy;
    logic          r_txd;
    logic          w_bit_end;

    assign w_bit_end = (r_cnt == CW'(BAUD_DIV - 1));
    assign o_done    = r_busy & w_bit_end & (r_bit == 4'd9);
    assign o_busy    = r_busy;
    assign o_txd     = r_txd;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_bit  <= '0;
            r_sh   <= '1;
            r_busy <= 1'b0;
            r_txd  <= 1'b1;
        end else if (i_load) begin
            r_cnt  <= '0;
            r_bit  <= '0;
            r_sh   <= {1'b1, i_byte};
            r_busy <= 1'b1;
            r_txd  <= 1'b0;
        end else if (r_busy) begin
            if (w_bit_end) begin
                r_cnt <= '0;
                r_bit <= r_bit + 4'd1;
                if (r_bit == 4'd9) begin
                    r_busy <= 1'b0;
                    r_txd  <= 1'b1;
                end else begin
                    // shift-in of ones makes the stop bit fall out last
                    r_txd <= r_sh[0];
                    r_sh  <= {1'b1, r_sh[8:1]};
                end
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/mpsoc_uart_bus_bridge.sv
// UART command receiver driving single-cycle msp430 peripheral-bus accesses.
module mpsoc_uart_bus_bridge
    import mpsoc_uart_bus_bridge_pkg::*;
#(
    parameter int BAUD_DIV     = 16,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic        mclk,
    input  logic        puc_rst_n,
    input  logic        uart_rxd,
    output logic        uart_txd,
    output logic [13:0] per_addr,
    output logic [15:0] per_din,
    output logic        per_en,
    output logic [1:0]  per_we,
    input  logic [15:0] per_dout,
    output logic        busy,
    output logic        frame_err
);
    localparam int CW     = $clog2(BAUD_DIV);
    localparam int HALF   = BAUD_DIV / 2;
    localparam int TO_LIM = TIMEOUT_BITS * BAUD_DIV;
    localparam int TW     = $clog2(TO_LIM + 2);

    logic          r_rx_s1, r_rx_s2, r_rx_s3;
    logic          r_rx_act;
    logic [CW-1:0] r_rx_cnt;
    logic [3:0]    r_rx_bit;
    logic [7:0]    r_rx_sh;
    logic          r_rx_vld;
    logic          r_rx_ferr;
    logic          w_rx_fall;

    state_t                r_state;
    logic                  r_wr;
    logic [ADDR_HI_W-1:0]  r_addr_hi;
    logic [7:0]            r_addr_lo;
    logic [7:0]            r_dlo;
    logic [7:0]            r_rd_hi;
    logic [TW-1:0]         r_to_cnt;
    logic [13:0]           r_per_addr;
    logic [15:0]           r_per_din;
    logic                  r_per_en;
    logic [1:0]            r_per_we;
    logic                  r_busy;
    logic                  r_ferr;

    logic       w_get;
    logic       w_to;
    logic       w_tx_load;
    logic [7:0] w_tx_byte;
    logic       w_tx_busy;
    logic       w_tx_done;

    assign w_rx_fall = r_rx_s3 & ~r_rx_s2;

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_s3   <= 1'b1;
            r_rx_act  <= 1'b0;
            r_rx_cnt  <= '0;
            r_rx_bit  <= '0;
            r_rx_sh   <= '0;
            r_rx_vld  <= 1'b0;
            r_rx_ferr <= 1'b0;
        end else begin
            r_rx_s1   <= uart_rxd;
            r_rx_s2   <= r_rx_s1;
            r_rx_s3   <= r_rx_s2;
            r_rx_vld  <= 1'b0;
            r_rx_ferr <= 1'b0;
            if (!r_rx_act) begin
                if (w_rx_fall) begin
                    r_rx_act <= 1'b1;
                    r_rx_cnt <= CW'(1);
                    r_rx_bit <= '0;
                end
            end else begin
                if (r_rx_cnt == CW'(BAUD_DIV - 1)) begin
                    r_rx_cnt <= '0;
                    r_rx_bit <= r_rx_bit + 4'd1;
                end else begin
                    r_rx_cnt <= r_rx_cnt + CW'(1);
                end
                if (r_rx_cnt == CW'(HALF)) begin
                    unique case (1'b1)
                        (r_rx_bit == 4'd0): begin
                            if (r_rx_s2) r_rx_act <= 1'b0;
                        end
                        (r_rx_bit == 4'd9): begin
                            r_rx_act  <= 1'b0;
                            r_rx_vld  <= r_rx_s2;
                            r_rx_ferr <= ~r_rx_s2;
                        end
                        default: r_rx_sh <= {r_rx_s2, r_rx_sh[7:1]};
                    endcase
                end
            end
        end
    end

    assign w_get = (r_state == S_GET_ALO) || (r_state == S_GET_DLO) ||
                   (r_state == S_GET_DHI);
    assign w_to  = w_get && (r_to_cnt > TW'(TO_LIM));

    // read data low byte goes straight from the bus so TX starts right after BUS
    assign w_tx_load = ((r_state == S_BUS) && !w_tx_busy) ||
                       ((r_state == S_SEND_B0) && w_tx_done && !r_wr);
    assign w_tx_byte = (r_state == S_BUS) ? (r_wr ? ACK_BYTE : per_dout[7:0])
                                          : r_rd_hi;

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            r_state    <= S_IDLE;
            r_wr       <= 1'b0;
            r_addr_hi  <= '0;
            r_addr_lo  <= '0;
            r_dlo      <= '0;
            r_rd_hi    <= '0;
            r_to_cnt   <= '0;
            r_per_addr <= '0;
            r_per_din  <= '0;
            r_per_en   <= 1'b0;
            r_per_we   <= 2'b00;
            r_busy     <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_per_en <= 1'b0;
            r_per_we <= 2'b00;
            r_ferr   <= r_rx_ferr | w_to;
            if (w_get && !r_rx_act) begin
                if (r_to_cnt != '1) r_to_cnt <= r_to_cnt + TW'(1);
            end else begin
                r_to_cnt <= '0;
            end
            if ((w_get && r_rx_ferr) || w_to) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: if (r_rx_vld) begin
                        r_wr      <= r_rx_sh[CMD_WR_BIT];
                        r_addr_hi <= r_rx_sh[ADDR_HI_W-1:0];
                        r_state   <= S_GET_ALO;
                        r_busy    <= 1'b1;
                    end
                    S_GET_ALO: if (r_rx_vld) begin
                        r_addr_lo <= r_rx_sh;
                        if (r_wr) begin
                            r_state <= S_GET_DLO;
                        end else begin
                            r_state    <= S_BUS;
                            r_per_en   <= 1'b1;
                            r_per_addr <= {r_addr_hi, r_rx_sh};
                        end
                    end
                    S_GET_DLO: if (r_rx_vld) begin
                        r_dlo   <= r_rx_sh;
                        r_state <= S_GET_DHI;
                    end
                    S_GET_DHI: if (r_rx_vld) begin
                        r_state    <= S_BUS;
                        r_per_en   <= 1'b1;
                        r_per_we   <= 2'b11;
                        r_per_addr <= {r_addr_hi, r_addr_lo};
                        r_per_din  <= {r_rx_sh, r_dlo};
                    end
                    S_BUS: begin
                        r_rd_hi <= per_dout[15:8];
                        r_state <= S_SEND_B0;
                    end
                    S_SEND_B0: if (w_tx_done) begin
                        if (r_wr) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_SEND_B1;
                        end
                    end
                    S_SEND_B1: if (w_tx_done) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    mpsoc_uart_bus_bridge_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx (
        .i_clk   (mclk),
        .i_rst_n (puc_rst_n),
        .i_load  (w_tx_load),
        .i_byte  (w_tx_byte),
        .o_busy  (w_tx_busy),
        .o_done  (w_tx_done),
        .o_txd   (uart_txd)
    );

    assign per_addr  = r_per_addr;
    assign per_din   = r_per_din;
    assign per_en    = r_per_en;
    assign per_we    = r_per_we;
    assign busy      = r_busy;
    assign frame_err = r_ferr;
endmodule

// File: tb/tb_mpsoc_uart_bus_bridge.sv
// Random command stream against a memory-backed peripheral and UART decoders.
`timescale 1ns/1ps
module tb_mpsoc_uart_bus_bridge;
    localparam int BD = 16;

    logic        mclk = 1'b0;
    logic        puc_rst_n = 1'b1;
    logic        uart_rxd = 1'b1;
    logic        uart_txd;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;
    logic        busy;
    logic        frame_err;

    always #5 mclk = ~mclk;

    mpsoc_uart_bus_bridge #(
        .BAUD_DIV     (BD),
        .TIMEOUT_BITS (64)
    ) dut (
        .mclk      (mclk),
        .puc_rst_n (puc_rst_n),
        .uart_rxd  (uart_rxd),
        .uart_txd  (uart_txd),
        .per_addr  (per_addr),
        .per_din   (per_din),
        .per_en    (per_en),
        .per_we    (per_we),
        .per_dout  (per_dout),
        .busy      (busy),
        .frame_err (frame_err)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ferr_n = 0;

    logic [15:0] mem     [0:16383];
    logic [15:0] exp_mem [0:16383];

    int          bq_t[$];
    logic [1:0]  bq_we[$];
    logic [13:0] bq_addr[$];
    logic [15:0] bq_din[$];
    logic [7:0]  tx_q[$];
    int          tx_t[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge mclk) cyc <= cyc + 1;

    assign per_dout = mem[per_addr];

    always @(posedge mclk)
        if (per_en && per_we == 2'b11) mem[per_addr] <= per_din;

    always @(negedge mclk) begin
        if (frame_err === 1'b1) ferr_n++;
        if (puc_rst_n && per_en === 1'b1) begin
            bq_t.push_back(cyc);
            bq_we.push_back(per_we);
            bq_addr.push_back(per_addr);
            bq_din.push_back(per_din);
        end
    end

    initial begin : txmon
        logic [7:0] b;
        int t0;
        forever begin
            @(negedge mclk);
            if (uart_txd === 1'b0) begin
                t0 = cyc;
                repeat (BD / 2 - 1) @(negedge mclk);
                if (uart_txd === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (BD) @(negedge mclk);
                        b[i] = uart_txd;
                    end
                    repeat (BD) @(negedge mclk);
                    check("tx_stop", uart_txd, 1'b1);
                    tx_q.push_back(b);
                    tx_t.push_back(t0);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge mclk);
    endtask

    task automatic uart_send(input logic [7:0] b, input logic stop = 1'b1);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rxd = f[i];
            repeat (BD) @(negedge mclk);
        end
        uart_rxd = 1'b1;
    endtask

    task automatic flush();
        bq_t.delete(); bq_we.delete(); bq_addr.delete(); bq_din.delete();
        tx_q.delete(); tx_t.delete();
    endtask

    task automatic do_cmd(input logic wr, input logic [13:0] a,
                          input logic [15:0] d);
        int nexp, t, f0;
        logic rsv;
        logic [15:0] ev;
        logic [7:0] eb [2];
        f0  = ferr_n;
        rsv = 1'($urandom);
        uart_send({wr, rsv, a[13:8]});
        idle($urandom_range(0, 60));
        uart_send(a[7:0]);
        if (wr) begin
            idle($urandom_range(0, 60));
            uart_send(d[7:0]);
            idle($urandom_range(0, 60));
            uart_send(d[15:8]);
            exp_mem[a] = d;
            nexp = 1;
            eb[0] = 8'hA5;
            eb[1] = 8'h00;
        end else begin
            ev = exp_mem[a];
            nexp = 2;
            eb[0] = ev[7:0];
            eb[1] = ev[15:8];
        end
        t = 0;
        while (tx_q.size() < nexp && t < 3000) begin
            @(negedge mclk);
            t++;
        end
        check("busy_tx", busy, 1'b1);
        check("rsp_count", tx_q.size(), nexp);
        check("bus_count", bq_we.size(), 1);
        if (bq_we.size() > 0) begin
            check("per_we", bq_we[0], wr ? 2'b11 : 2'b00);
            check("per_addr", bq_addr[0], a);
            if (wr) check("per_din", bq_din[0], d);
            if (tx_t.size() > 0) check("tx_latency", tx_t[0] - bq_t[0], 1);
        end
        if (!wr && tx_t.size() > 1) check("tx_gap", tx_t[1] - tx_t[0], 10 * BD);
        for (int i = 0; i < nexp; i++)
            if (tx_q.size() > 0) check("tx_byte", tx_q.pop_front(), eb[i]);
        t = 0;
        while (busy && t < 24) begin
            @(negedge mclk);
            t++;
        end
        check("busy_fall", busy, 1'b0);
        check("no_ferr", ferr_n - f0, 0);
        flush();
        idle($urandom_range(0, 40));
    endtask

    logic [13:0] pool [4];

    initial begin
        int f0, t;
        logic [13:0] ra;
        for (int i = 0; i < 16384; i++) begin
            mem[i] = 16'(i * 40503) ^ 16'h5A3C;
            exp_mem[i] = mem[i];
        end
        mem[14'h0012] = 16'hBEEF;
        exp_mem[14'h0012] = 16'hBEEF;
        pool[0] = 14'h0010; pool[1] = 14'h0012;
        pool[2] = 14'h3FFF; pool[3] = 14'h2A55;

        #1 puc_rst_n = 1'b0;
        idle(3);
        check("rst_txd", uart_txd, 1'b1);
        check("rst_per_en", per_en, 1'b0);
        check("rst_per_we", per_we, 2'b00);
        check("rst_per_addr", per_addr, 14'h0);
        check("rst_per_din", per_din, 16'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        puc_rst_n = 1'b1;
        idle(20);

        do_cmd(1'b1, 14'h0010, 16'h1234);
        do_cmd(1'b0, 14'h0012, 16'h0000);
        do_cmd(1'b0, 14'h0010, 16'h0000);

        f0 = ferr_n;
        uart_send(8'h00);
        idle(5);
        uart_send(8'h12, 1'b0);
        idle(40);
        check("stop_ferr", ferr_n - f0, 1);
        check("stop_no_bus", bq_we.size(), 0);
        check("stop_busy", busy, 1'b0);
        flush();
        do_cmd(1'b0, 14'h0012, 16'h0000);

        f0 = ferr_n;
        uart_send(8'h80);
        idle(64 * BD + 10);
        check("to_ferr", ferr_n - f0, 1);
        check("to_busy", busy, 1'b0);
        check("to_no_bus", bq_we.size(), 0);
        flush();
        idle(20);

        f0 = ferr_n;
        uart_rxd = 1'b0;
        idle(3);
        uart_rxd = 1'b1;
        idle(300);
        check("glitch_busy", busy, 1'b0);
        check("glitch_ferr", ferr_n - f0, 0);
        check("glitch_bus", bq_we.size(), 0);

        for (int n = 0; n < 16; n++) begin
            ra = ($urandom % 2) ? pool[$urandom % 4] : 14'($urandom);
            do_cmd(1'($urandom), ra, 16'($urandom));
        end

        uart_send(8'h00);
        uart_send(8'h12);
        t = 0;
        while (uart_txd !== 1'b0 && t < 400) begin
            @(negedge mclk);
            t++;
        end
        check("rst_tx_started", uart_txd, 1'b0);
        idle(3);
        puc_rst_n = 1'b0;
        #1;
        check("rst_mid_txd", uart_txd, 1'b1);
        check("rst_mid_per_en", per_en, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        idle(4);
        puc_rst_n = 1'b1;
        idle(200);
        flush();
        do_cmd(1'b0, 14'h0012, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
